load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 32-bit data and 32-bit byte address.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  core presents an access request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RISC-V size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 resp_err  output  1  misaligned address or illegal funct3; qualified by resp_valid.
REQ-013 mem_addr  output  32  word-aligned address to data memory ({addr[31:2],2'b00}).
REQ-014 mem_wdata  output  32  full word to write.
REQ-015 mem_we / mem_re  output  1 each  word write enable / read enable to data memory.
REQ-016 mem_rdata  input  32  combinational word read data from data memory (same cycle as mem_re).

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RMW_RD, WRITE, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; handshake occurs when req_valid && req_ready; request fields latched at that edge.
REQ-019 Error check at acceptance: H with addr[0]!=0, W with addr[1:0]!=0, funct3 in {011,110,111}, or store with funct3 in {100,101} SHALL go IDLE->RESP with resp_err=1, no mem_re/mem_we ever asserted.
REQ-020 Legal load: IDLE->LOAD->RESP; in LOAD mem_re=1, extracted result registered at end of LOAD; resp_valid 2 cycles after acceptance.
REQ-021 Load extraction: byte lane addr[1:0], halfword lane addr[1]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-022 Legal SW: IDLE->WRITE->RESP; mem_we=1 with mem_wdata=req_wdata for exactly one cycle; resp 2 cycles after acceptance.
REQ-023 Legal SB/SH: IDLE->RMW_RD->WRITE->RESP; RMW_RD asserts mem_re and registers mem_rdata; WRITE writes that word with only the addressed byte/halfword replaced by req_wdata[7:0]/[15:0]; resp 3 cycles after acceptance.
REQ-024 mem_we SHALL be 1 only in WRITE, mem_re only in LOAD or RMW_RD, never both; mem_addr constant for the whole transaction.
REQ-025 RESP SHALL last exactly one cycle then return to IDLE; resp_rdata/resp_err hold until next RESP.
REQ-026 Requests presented while req_ready=0 SHALL be ignored (no latching, no side effects).
REQ-027 Back-to-back: a new request may be accepted in the cycle immediately after RESP.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, merge register=0.
REQ-029 rst asserted mid-transaction SHALL abort it: no write issued after rst, no resp_valid for the aborted request.

Verification
REQ-030 Mem word @0x10=0x8899AABB; LB addr 0x13 -> resp 2 cycles later, rdata 0xFFFFFF88, err 0; LBU same addr -> 0x00000088.
REQ-031 Mem @0x20=0x11223344; SB addr 0x21 wdata 0xDEADBEEF -> mem_re in cycle+1, mem_we in cycle+2 with mem_wdata 0x1122EF44, resp cycle+3; subsequent LW 0x20 returns 0x1122EF44.
REQ-032 LH addr 0x0F -> resp_valid cycle+1, err=1, rdata 0, mem_re/mem_we never asserted; SW addr 0x06 likewise err=1.
REQ-033 SW 0x40 wdata 0xCAFEF00D held with req_valid continuously -> exactly one mem_we pulse, req_ready low 2 cycles, second request accepted only after RESP.
REQ-034 SH addr 0x42, rst pulsed during WRITE state -> mem_we drops same cycle, no resp_valid, word @0x40 unchanged, FSM in IDLE.
REQ-035 LHU addr 0x12 over word 0x8899AABB -> 0x00008899; LH -> 0xFFFF8899.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - word-memory load/store unit with byte/halfword extraction and read-modify-write stores
// Accepts one access at a time; sub-word stores merge into the existing word before writing it back.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state, state_next;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  // Holds store data from acceptance, then the merged word for sub-word stores.
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_bad;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    req_bad = 1'b0;
    case (req_funct3)
      F3_B:    req_bad = 1'b0;
      F3_H:    req_bad = req_addr[0];
      F3_W:    req_bad = |req_addr[1:0];
      F3_BU:   req_bad = req_we;
      F3_HU:   req_bad = req_we | req_addr[0];
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    lane_byte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0: lane_byte = mem_rdata[7:0];
      2'd1: lane_byte = mem_rdata[15:8];
      2'd2: lane_byte = mem_rdata[23:16];
      2'd3: lane_byte = mem_rdata[31:24];
      default: lane_byte = mem_rdata[7:0];
    endcase
    lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    load_val = mem_rdata;
    case (funct3_q)
      F3_B:    load_val = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    load_val = {{16{lane_half[15]}}, lane_half};
      F3_BU:   load_val = {24'd0, lane_byte};
      F3_HU:   load_val = {16'd0, lane_half};
      default: load_val = mem_rdata;
    endcase
  end

  // Only the addressed lane is replaced; the rest of the word comes from memory.
  always_comb begin
    merged = mem_rdata;
    if (funct3_q[0]) begin
      if (addr_q[1]) merged[31:16] = merge_q[15:0];
      else           merged[15:0]  = merge_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = merge_q[7:0];
        2'd1: merged[15:8]  = merge_q[7:0];
        2'd2: merged[23:16] = merge_q[7:0];
        2'd3: merged[31:24] = merge_q[7:0];
        default: merged = mem_rdata;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)                  state_next = RESP;
          else if (!req_we)             state_next = LOAD;
          else if (req_funct3 == F3_W)  state_next = WRITE;
          else                          state_next = RMW_RD;
        end
      end
      LOAD:    state_next = RESP;
      RMW_RD:  state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= 32'd0;
      funct3_q <= 3'd0;
      merge_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            merge_q  <= req_wdata;
            if (req_bad) begin
              rdata_q <= 32'd0;
              err_q   <= 1'b1;
            end
          end
        end
        LOAD: begin
          rdata_q <= load_val;
          err_q   <= 1'b0;
        end
        RMW_RD: merge_q <= merged;
        WRITE: begin
          rdata_q <= 32'd0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = merge_q;
  assign mem_we     = (state == WRITE);
  assign mem_re     = (state == LOAD) || (state == RMW_RD);

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
// A small word memory model sits behind the unit; each task checks one scenario.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;

  int          r_resp_cyc;
  logic [31:0] r_rdata;
  logic        r_err;
  int          r_re_cnt;
  int          r_we_cnt;
  int          r_re_cyc;
  int          r_we_cyc;
  logic [31:0] r_wdata;
  logic        r_addr_bad;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  // Issue one request and record what the unit does over the following five cycles.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL txn_ready_at_issue got %b exp 1", req_ready);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_valid  = 1'b0;
    r_resp_cyc = -1;
    r_rdata    = 32'hx;
    r_err      = 1'bx;
    r_re_cnt   = 0;
    r_we_cnt   = 0;
    r_re_cyc   = -1;
    r_we_cyc   = -1;
    r_wdata    = 32'hx;
    r_addr_bad = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (mem_re) begin r_re_cnt++; r_re_cyc = k; end
      if (mem_we) begin r_we_cnt++; r_we_cyc = k; r_wdata = mem_wdata; end
      if ((mem_re || mem_we) && mem_addr !== {addr[31:2], 2'b00}) r_addr_bad = 1'b1;
      if (resp_valid && r_resp_cyc < 0) begin
        r_resp_cyc = k;
        r_rdata    = resp_rdata;
        r_err      = resp_err;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL rst_resp got valid=%b err=%b exp 0 0", resp_valid, resp_err);
    end
    checks++;
    if (resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
    checks++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
      errors++; $display("FAIL rst_mem_en got we=%b re=%b exp 0 0", mem_we, mem_re);
    end
    checks++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      errors++; $display("FAIL rst_mem_bus got addr=%h wdata=%h exp 0 0", mem_addr, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_byte;
    mem[4] = 32'h8899AABB;
    run_txn(1'b0, 3'b000, 32'h13, 32'h0);
    checks++;
    if (r_resp_cyc !== 2) begin errors++; $display("FAIL lb_latency got %0d exp 2", r_resp_cyc); end
    checks++;
    if (r_rdata !== 32'hFFFFFF88 || r_err !== 1'b0) begin
      errors++; $display("FAIL lb_data got %h err=%b exp ffffff88 err=0", r_rdata, r_err);
    end
    checks++;
    if (r_re_cnt !== 1 || r_re_cyc !== 1 || r_we_cnt !== 0 || r_addr_bad) begin
      errors++;
      $display("FAIL lb_mem got re_cnt=%0d re_cyc=%0d we_cnt=%0d addr_bad=%b exp 1 1 0 0",
               r_re_cnt, r_re_cyc, r_we_cnt, r_addr_bad);
    end
    run_txn(1'b0, 3'b100, 32'h13, 32'h0);
    checks++;
    if (r_rdata !== 32'h00000088) begin errors++; $display("FAIL lbu_data got %h exp 00000088", r_rdata); end
    run_txn(1'b0, 3'b000, 32'h10, 32'h0);
    checks++;
    if (r_rdata !== 32'hFFFFFFBB) begin errors++; $display("FAIL lb_lane0 got %h exp ffffffbb", r_rdata); end
    run_txn(1'b0, 3'b100, 32'h11, 32'h0);
    checks++;
    if (r_rdata !== 32'h000000AA) begin errors++; $display("FAIL lbu_lane1 got %h exp 000000aa", r_rdata); end
  endtask

  task automatic test_load_half_word;
    run_txn(1'b0, 3'b101, 32'h12, 32'h0);
    checks++;
    if (r_rdata !== 32'h00008899) begin errors++; $display("FAIL lhu_data got %h exp 00008899", r_rdata); end
    run_txn(1'b0, 3'b001, 32'h12, 32'h0);
    checks++;
    if (r_rdata !== 32'hFFFF8899) begin errors++; $display("FAIL lh_data got %h exp ffff8899", r_rdata); end
    run_txn(1'b0, 3'b001, 32'h10, 32'h0);
    checks++;
    if (r_rdata !== 32'hFFFFAABB) begin errors++; $display("FAIL lh_low got %h exp ffffaabb", r_rdata); end
    run_txn(1'b0, 3'b010, 32'h10, 32'h0);
    checks++;
    if (r_rdata !== 32'h8899AABB || r_resp_cyc !== 2) begin
      errors++; $display("FAIL lw_data got %h cyc=%0d exp 8899aabb cyc=2", r_rdata, r_resp_cyc);
    end
  endtask

  task automatic test_store_sub_word;
    mem[8] = 32'h11223344;
    run_txn(1'b1, 3'b000, 32'h21, 32'hDEADBEEF);
    checks++;
    if (r_re_cyc !== 1 || r_we_cyc !== 2 || r_re_cnt !== 1 || r_we_cnt !== 1 || r_addr_bad) begin
      errors++;
      $display("FAIL sb_timing got re_cyc=%0d we_cyc=%0d re_cnt=%0d we_cnt=%0d addr_bad=%b exp 1 2 1 1 0",
               r_re_cyc, r_we_cyc, r_re_cnt, r_we_cnt, r_addr_bad);
    end
    checks++;
    if (r_wdata !== 32'h1122EF44) begin errors++; $display("FAIL sb_wdata got %h exp 1122ef44", r_wdata); end
    checks++;
    if (r_resp_cyc !== 3 || r_err !== 1'b0 || r_rdata !== 32'd0) begin
      errors++; $display("FAIL sb_resp got cyc=%0d err=%b rdata=%h exp 3 0 0", r_resp_cyc, r_err, r_rdata);
    end
    run_txn(1'b0, 3'b010, 32'h20, 32'h0);
    checks++;
    if (r_rdata !== 32'h1122EF44) begin errors++; $display("FAIL sb_readback got %h exp 1122ef44", r_rdata); end
    run_txn(1'b1, 3'b001, 32'h22, 32'h00005566);
    checks++;
    if (r_wdata !== 32'h5566EF44 || r_resp_cyc !== 3) begin
      errors++; $display("FAIL sh_wdata got %h cyc=%0d exp 5566ef44 cyc=3", r_wdata, r_resp_cyc);
    end
    checks++;
    if (mem[8] !== 32'h5566EF44) begin errors++; $display("FAIL sh_mem got %h exp 5566ef44", mem[8]); end
  endtask

  task automatic test_errors;
    run_txn(1'b0, 3'b001, 32'h0F, 32'h0);
    checks++;
    if (r_resp_cyc !== 1 || r_err !== 1'b1 || r_rdata !== 32'd0) begin
      errors++; $display("FAIL lh_misalign got cyc=%0d err=%b rdata=%h exp 1 1 0", r_resp_cyc, r_err, r_rdata);
    end
    checks++;
    if (r_re_cnt !== 0 || r_we_cnt !== 0) begin
      errors++; $display("FAIL lh_misalign_mem got re=%0d we=%0d exp 0 0", r_re_cnt, r_we_cnt);
    end
    run_txn(1'b1, 3'b010, 32'h06, 32'h12345678);
    checks++;
    if (r_resp_cyc !== 1 || r_err !== 1'b1 || r_re_cnt !== 0 || r_we_cnt !== 0) begin
      errors++; $display("FAIL sw_misalign got cyc=%0d err=%b re=%0d we=%0d exp 1 1 0 0",
                         r_resp_cyc, r_err, r_re_cnt, r_we_cnt);
    end
    run_txn(1'b0, 3'b011, 32'h10, 32'h0);
    checks++;
    if (r_err !== 1'b1 || r_re_cnt !== 0) begin
      errors++; $display("FAIL bad_funct3 got err=%b re=%0d exp 1 0", r_err, r_re_cnt);
    end
    run_txn(1'b1, 3'b100, 32'h10, 32'h0);
    checks++;
    if (r_err !== 1'b1 || r_we_cnt !== 0 || r_re_cnt !== 0 || mem[4] !== 32'h8899AABB) begin
      errors++; $display("FAIL store_bu got err=%b we=%0d re=%0d mem=%h exp 1 0 0 8899aabb",
                         r_err, r_we_cnt, r_re_cnt, mem[4]);
    end
  endtask

  task automatic test_back_to_back;
    int we_pulses;
    int ready_low;
    logic second_we;
    we_pulses = 0;
    ready_low = 0;
    second_we = 1'b0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h40;
    req_wdata  = 32'hCAFEF00D;
    for (int k = 0; k <= 4; k++) begin
      if (k <= 3 && mem_we) we_pulses++;
      if (k <= 3 && !req_ready) ready_low++;
      if (k == 4) second_we = mem_we;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (we_pulses !== 1) begin errors++; $display("FAIL b2b_we_pulses got %0d exp 1", we_pulses); end
    checks++;
    if (ready_low !== 2) begin errors++; $display("FAIL b2b_ready_low got %0d exp 2", ready_low); end
    checks++;
    if (second_we !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got %b exp 1", second_we); end
    checks++;
    if (mem[16] !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_mem got %h exp cafef00d", mem[16]); end
  endtask

  task automatic test_reset_abort;
    int resp_seen;
    resp_seen = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h42;
    req_wdata  = 32'h00001234;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL abort_in_write got we=%b exp 1", mem_we); end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL abort_async got we=%b ready=%b resp=%b exp 0 1 0", mem_we, req_ready, resp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) resp_seen++;
      @(negedge clk);
    end
    checks++;
    if (resp_seen !== 0) begin errors++; $display("FAIL abort_no_resp got %0d exp 0", resp_seen); end
    checks++;
    if (mem[16] !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_mem got %h exp cafef00d", mem[16]); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_idle got %b exp 1", req_ready); end
    run_txn(1'b0, 3'b010, 32'h40, 32'h0);
    checks++;
    if (r_rdata !== 32'hCAFEF00D || r_resp_cyc !== 2) begin
      errors++; $display("FAIL abort_reload got %h cyc=%0d exp cafef00d cyc=2", r_rdata, r_resp_cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    test_reset;
    test_load_byte;
    test_load_half_word;
    test_store_sub_word;
    test_errors;
    test_back_to_back;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
